misa_ext_ctrl: RTL

- Runtime-writable MISA controller. Extends the compile-time extension enables (FPU, C, A, CVXIF) with a software-controllable enable layer.
- Sits beside the CSR file: accepts MISA writes, sequences a pipeline flush/drain, then atomically commits the new per-extension enables to decode/issue.
- An extension is runtime-switchable only when its compile-time parameter is 1; otherwise it is hard-wired off.

---
 rtl/misa_ctrl_pkg.sv | 45 ++++
 rtl/misa_drain_timer.sv | 35 +++
 rtl/misa_ext_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/misa_ctrl_pkg.sv
// Shared definitions for the runtime-writable MISA controller:
// FSM state encoding, MISA bit positions, MXL lookup and writable-mask builder.
package misa_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Only the low 26 bits (extension letters A..Z) are modelled as a register.
    localparam int EXT_W  = 26;

    localparam int MISA_A = 0;
    localparam int MISA_C = 2;
    localparam int MISA_D = 3;
    localparam int MISA_F = 5;
    localparam int MISA_I = 8;
    localparam int MISA_M = 12;
    localparam int MISA_S = 18;
    localparam int MISA_U = 20;
    localparam int MISA_X = 23;

    // Letters that always read as 1 regardless of configuration.
    localparam logic [EXT_W-1:0] FIXED_BITS = (EXT_W'(1) << MISA_I) | (EXT_W'(1) << MISA_M) |
                                              (EXT_W'(1) << MISA_S) | (EXT_W'(1) << MISA_U);

    function automatic logic [1:0] mxl_for(input int xlen);
        return (xlen == 64) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [EXT_W-1:0] writable_mask(input logic fpu, input logic cext,
                                                       input logic aext, input logic cvxif);
        logic [EXT_W-1:0] m;
        m         = '0;
        m[MISA_A] = aext;
        m[MISA_C] = cext;
        m[MISA_D] = fpu;
        m[MISA_F] = fpu;
        m[MISA_X] = cvxif;
        return m;
    endfunction

endpackage

// File: rtl/misa_drain_timer.sv
// Saturating cycle counter used to bound the flush/drain handshake.
// A DRAIN_TIMEOUT of 0 disables expiry entirely.
module misa_drain_timer #(
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (DRAIN_TIMEOUT < 2) ? 1 : $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DRAIN_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Clear wins over counting so a fresh sequence always starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign expired = (DRAIN_TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/misa_ext_ctrl.sv
// Runtime-writable MISA controller: legalises MISA writes, sequences a
// pipeline flush/drain, then atomically commits the new extension enables.
// Optional macro CVA6_MISA_CHG_CNT_EN adds a committed-reconfiguration counter.
module misa_ext_ctrl
    import misa_ctrl_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int FPU_EN        = 1,
    parameter int CEXT_EN       = 1,
    parameter int AEXT_EN       = 1,
    parameter int CVXIF_EN      = 1,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            csr_we_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            csr_ready_o,
    output logic [XLEN-1:0] misa_o,
    input  logic            pc_aligned_i,
    output logic            flush_req_o,
    input  logic            flush_ack_i,
    input  logic            pipe_empty_i,
    output logic            fpu_en_o,
    output logic            cext_en_o,
    output logic            aext_en_o,
    output logic            cvxif_en_o,
    output logic            err_o,
    output logic [15:0]     chg_cnt_o
);

    localparam logic [EXT_W-1:0] WMASK = writable_mask(FPU_EN != 0, CEXT_EN != 0,
                                                       AEXT_EN != 0, CVXIF_EN != 0);
    localparam logic [1:0]       MXL   = mxl_for(XLEN);

    state_t           state;
    state_t           state_next;
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] pending;
    logic [EXT_W-1:0] legal;
    logic             accept;
    logic             commit;
    logic             tmr_clr;
    logic             tmr_en;
    logic             expired;
    logic             wdata_unused;

    // Upper write-data bits map to MXL/reserved fields which are read-only.
    assign wdata_unused = ^csr_wdata_i[XLEN-1:EXT_W];

    // Legalise the incoming write against the current committed value.
    always_comb begin
        legal = csr_wdata_i[EXT_W-1:0] & WMASK;
        // D without F is not a legal combination.
        if (legal[MISA_D] && !legal[MISA_F]) begin
            legal[MISA_D] = 1'b0;
        end
        // Dropping C while the next PC is only 2-byte aligned would strand fetch.
        if (ext[MISA_C] && !legal[MISA_C] && !pc_aligned_i) begin
            legal[MISA_C] = 1'b1;
        end
    end

    // Next-state and control outputs; timeout abort loses only to COMMIT.
    always_comb begin
        state_next  = state;
        csr_ready_o = 1'b0;
        flush_req_o = 1'b0;
        err_o       = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        unique case (state)
            IDLE: begin
                csr_ready_o = 1'b1;
                if (csr_we_i && (legal != ext)) begin
                    accept     = 1'b1;
                    tmr_clr    = 1'b1;
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                tmr_en = 1'b1;
                if (expired) begin
                    err_o      = 1'b1;
                    state_next = IDLE;
                end else begin
                    flush_req_o = 1'b1;
                    if (flush_ack_i) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                tmr_en = 1'b1;
                if (pipe_empty_i) begin
                    state_next = COMMIT;
                end else if (expired) begin
                    err_o      = 1'b1;
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Committed extension bits change only when leaving COMMIT.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ext <= WMASK;
        end else if (commit) begin
            ext <= pending;
        end
    end

    // Pending value is only meaningful between accept and commit, so no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pending <= legal;
        end
    end

    misa_drain_timer #(
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) u_timer (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(expired)
    );

`ifdef CVA6_MISA_CHG_CNT_EN
    logic [15:0] chg_cnt;

    // Count committed reconfigurations; wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chg_cnt <= '0;
        end else if (commit) begin
            chg_cnt <= chg_cnt + 16'd1;
        end
    end

    assign chg_cnt_o = chg_cnt;
`else
    assign chg_cnt_o = '0;
`endif

    assign misa_o     = {MXL, {(XLEN-EXT_W-2){1'b0}}, ext | FIXED_BITS};
    assign fpu_en_o   = ext[MISA_F];
    assign cext_en_o  = ext[MISA_C];
    assign aext_en_o  = ext[MISA_A];
    assign cvxif_en_o = ext[MISA_X];

endmodule
